// File: rtl/audio_i2s_pkg.sv
// Shared constants for the I2S transmitter: frame geometry, MCLK accumulator defaults
// and the FIFO level-width helper.
package audio_i2s_pkg;
  localparam int SLOT_BITS   = 32;
  localparam int FRAME_SLOTS = 64;
  localparam int MCLK_DIV    = 4;
  localparam int ACC_W       = 22;
  localparam int ACC_INC_DEF = 245760;
  localparam int ACC_MOD_DEF = 742500;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-pair FIFO with occupancy output; push when full and pop when
// empty are ignored.
module audio_sample_fifo import audio_i2s_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rd_data,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      empty
);
  localparam int LW = lvl_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (level_q < LW'(DEPTH));
    pop_ok   = pop && (level_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign empty   = (level_q == '0);
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: MCLK/SCLK/LRCK derived by clock-enable ticks from clk, samples fed
// through a small FIFO. Define I2S_UNDERFLOW_HOLD_EN to repeat the last frame on underflow.
module audio_i2s_tx import audio_i2s_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_INC    = ACC_INC_DEF,
  parameter int ACC_MOD    = ACC_MOD_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data_l,
  input  logic [DATA_WIDTH-1:0]          s_data_r,
  output logic [lvl_w(FIFO_DEPTH)-1:0]   fifo_level,
  output logic                           underflow,
  output logic                           underflow_sticky,
  output logic                           audio_mclk,
  output logic                           audio_lrck,
  output logic                           audio_dac
);
  localparam int LW  = lvl_w(FIFO_DEPTH);
  localparam int SW  = $clog2(FRAME_SLOTS);
  localparam int PW  = $clog2(SLOT_BITS);
  localparam int DVW = $clog2(MCLK_DIV);
  localparam logic [ACC_W-1:0] INC = ACC_W'(ACC_INC);
  localparam logic [ACC_W-1:0] MOD = ACC_W'(ACC_MOD);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DVW-1:0] div_q, div_d;
  logic [SW-1:0] slot_q, slot_d, next_slot;
  logic mclk_q, mclk_d, lrck_q, lrck_d, dac_q, dac_d;
  logic underflow_q, underflow_d, sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, sample;
  logic [SLOT_BITS-1:0] word;
  logic mclk_rise, sclk_fall, pop, fifo_empty;
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic [LW-1:0] level;

  audio_sample_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (s_valid && s_ready),
    .wr_data ({s_data_l, s_data_r}),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (level),
    .empty   (fifo_empty)
  );

  // Ready comes from the registered level only, so a same-cycle pop never frees a slot.
  assign s_ready = (level < LW'(FIFO_DEPTH));

  always_comb begin
    acc_d       = acc_q + INC;
    mclk_d      = mclk_q;
    div_d       = div_q;
    slot_d      = slot_q;
    lrck_d      = lrck_q;
    dac_d       = dac_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    underflow_d = 1'b0;
    sticky_d    = sticky_q;
    pop         = 1'b0;
    next_slot   = slot_q + SW'(1);
    mclk_rise   = (acc_q >= MOD) && !mclk_q;
    sclk_fall   = mclk_rise && (div_q == '1);
    if (acc_q >= MOD) begin
      acc_d  = acc_q - MOD + INC;
      mclk_d = ~mclk_q;
    end
    if (mclk_rise) div_d = div_q + DVW'(1);
    // Slot word: delay bit, sample MSB-first, zero padding; p==0 selects the delay bit.
    sample = next_slot[SW-1] ? hold_r_q : hold_l_q;
    word   = SLOT_BITS'({1'b0, sample}) << (SLOT_BITS - 1 - DATA_WIDTH);
    if (sclk_fall) begin
      slot_d = next_slot;
      lrck_d = next_slot[SW-1];
      dac_d  = word[~next_slot[PW-1:0]];
      if (slot_q == '1) begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          hold_l_d = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
          hold_r_d = rd_data[DATA_WIDTH-1:0];
        end else begin
          underflow_d = 1'b1;
          sticky_d    = 1'b1;
`ifdef I2S_UNDERFLOW_HOLD_EN
          hold_l_d = hold_l_q;
          hold_r_d = hold_r_q;
`else
          hold_l_d = '0;
          hold_r_d = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      mclk_q      <= 1'b0;
      div_q       <= '0;
      slot_q      <= '0;
      lrck_q      <= 1'b0;
      dac_q       <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mclk_q      <= mclk_d;
      div_q       <= div_d;
      slot_q      <= slot_d;
      lrck_q      <= lrck_d;
      dac_q       <= dac_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

  assign fifo_level       = level;
  assign underflow        = underflow_q;
  assign underflow_sticky = sticky_q;
  assign audio_mclk       = mclk_q;
  assign audio_lrck       = lrck_q;
  assign audio_dac        = dac_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: rate counts, slot bit patterns, FIFO fill/drain,
// underflow and asynchronous reset.
module tb_audio_i2s_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst24_n, rst_r_n;
  logic v16, rdy16, uf16, ufs16, mclk16, lrck16, dac16;
  logic [15:0] l16, r16;
  logic [3:0]  lvl16;
  logic v24, rdy24, uf24, ufs24, mclk24, lrck24, dac24;
  logic [23:0] l24, r24;
  logic [3:0]  lvl24;
  logic rdy_r, uf_r, ufs_r, mclk_r, lrck_r, dac_r;
  logic [15:0] zero16;
  logic [3:0]  lvl_r;

  audio_i2s_tx #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(rst_n), .s_valid(v16), .s_ready(rdy16), .s_data_l(l16), .s_data_r(r16),
    .fifo_level(lvl16), .underflow(uf16), .underflow_sticky(ufs16), .audio_mclk(mclk16),
    .audio_lrck(lrck16), .audio_dac(dac16));

  audio_i2s_tx #(.DATA_WIDTH(24)) dut24 (
    .clk(clk), .reset_n(rst24_n), .s_valid(v24), .s_ready(rdy24), .s_data_l(l24), .s_data_r(r24),
    .fifo_level(lvl24), .underflow(uf24), .underflow_sticky(ufs24), .audio_mclk(mclk24),
    .audio_lrck(lrck24), .audio_dac(dac24));

  audio_i2s_tx #(.DATA_WIDTH(16)) dut_r (
    .clk(clk), .reset_n(rst_r_n), .s_valid(1'b0), .s_ready(rdy_r), .s_data_l(zero16), .s_data_r(zero16),
    .fifo_level(lvl_r), .underflow(uf_r), .underflow_sticky(ufs_r), .audio_mclk(mclk_r),
    .audio_lrck(lrck_r), .audio_dac(dac_r));

  int n_run = 0;
  int n_fail = 0;
  int uf_cnt = 0;
  bit use24 = 1'b0;
  logic m_s = 1'b0, lr_s = 1'b0, d_s = 1'b0, m_rise = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One negedge sample of the selected DUT; underflow pulses of dut are tallied here.
  task automatic step();
    logic pm;
    @(negedge clk);
    pm     = m_s;
    m_s    = use24 ? mclk24 : mclk16;
    lr_s   = use24 ? lrck24 : lrck16;
    d_s    = use24 ? dac24  : dac16;
    m_rise = !pm && m_s;
    if (uf16) uf_cnt++;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    if (use24) begin v24 = 1'b1; l24 = l; r24 = r; end
    else begin v16 = 1'b1; l16 = l[15:0]; r16 = r[15:0]; end
    step();
    v16 = 1'b0;
    v24 = 1'b0;
  endtask

  task automatic wait_lr(input logic want, output bit ok);
    logic prev;
    prev = lr_s;
    ok = 1'b0;
    for (int i = 0; i < 3200 && !ok; i++) begin
      step();
      if (prev != want && lr_s == want) ok = 1'b1;
      prev = lr_s;
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    int c;
    c = 0;
    ok = 1'b0;
    for (int i = 0; i < 64 * n && !ok; i++) begin
      step();
      if (m_rise) c++;
      if (c == n) ok = 1'b1;
    end
  endtask

  // Capture the 32 slot bits of the channel that starts at the next LRCK edge to ch.
  task automatic cap(input logic ch, input string tag, input logic [31:0] exp);
    logic [31:0] w;
    bit ok;
    w = '0;
    wait_lr(ch, ok);
    chk({tag, "_edge"}, 32'(ok), 32'd1);
    if (ok) begin
      w[31] = d_s;
      for (int s = 30; s >= 0; s--) begin
        wait_rises(4, ok);
        w[s] = d_s;
      end
    end
    chk(tag, w, exp);
  endtask

  task automatic rst16();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic rate_test();
    logic pm, plr;
    int rises, edges, dac_hi, ufs;
    rises = 0; edges = 0; dac_hi = 0; ufs = 0;
    pm = mclk_r; plr = lrck_r;
    rst_r_n = 1'b1;
    for (int i = 0; i < 74250; i++) begin
      @(negedge clk);
      if (!pm && mclk_r) rises++;
      if (plr != lrck_r) edges++;
      if (dac_r) dac_hi++;
      if (uf_r) ufs++;
      pm = mclk_r; plr = lrck_r;
    end
    chk("rate_mclk_rises", rises, 32'd12288);
    chk("rate_lrck_edges", edges, 32'd96);
    chk("rate_dac_high", dac_hi, 32'd0);
    chk("rate_underflows", ufs, 32'd48);
    chk("rate_sticky", 32'(ufs_r), 32'd1);
  endtask

  task automatic main_tests();
    bit ok;
    int cnt;
    logic [31:0] exp3;
    rst_n = 1'b1;
    step();
    step();
    // Slot bit patterns, 16-bit
    rst16();
    for (int i = 0; i < 4; i++) push(24'h008001, 24'h007FFE);
    cap(1'b0, "d16_left", 32'h4000_8000);
    cap(1'b1, "d16_right", 32'h3FFF_0000);
    // FIFO fill to full and drain by one at the frame boundary
    rst16();
    for (int i = 0; i < 8; i++) push(24'h1000 + 24'(i), 24'h2000 + 24'(i));
    chk("fill_level", 32'(lvl16), 32'd8);
    chk("fill_ready", 32'(rdy16), 32'd0);
    v16 = 1'b1; l16 = 16'hDEAD; r16 = 16'hBEEF;
    step();
    step();
    v16 = 1'b0;
    chk("fill_ninth_rejected", 32'(lvl16), 32'd8);
    wait_lr(1'b0, ok);
    chk("fill_boundary_seen", 32'(ok), 32'd1);
    chk("drain_level", 32'(lvl16), 32'd7);
    chk("drain_ready", 32'(rdy16), 32'd1);
    cap(1'b0, "fifo_order", 32'h0800_8000);
    // Underflow after two fed frames
    rst16();
    uf_cnt = 0;
    push(24'h1234, 24'h5678);
    push(24'h0F0F, 24'hF0F0);
    cap(1'b0, "uf_frame1", 32'h091A_0000);
    cap(1'b0, "uf_frame2", 32'h0787_8000);
`ifdef I2S_UNDERFLOW_HOLD_EN
    exp3 = 32'h0787_8000;
`else
    exp3 = 32'h0000_0000;
`endif
    cap(1'b0, "uf_frame3", exp3);
    chk("uf_pulses", uf_cnt, 32'd1);
    wait_lr(1'b1, ok);
    chk("uf_sticky_held", 32'(ufs16), 32'd1);
    // Asynchronous reset mid right channel with entries queued
    for (int i = 0; i < 4; i++) push(24'h0100 + 24'(i), 24'h0200 + 24'(i));
    wait_lr(1'b1, ok);
    chk("rst_lrck_high_before", 32'(lrck16), 32'd1);
    for (int i = 0; i < 5; i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_lrck", 32'(lrck16), 32'd0);
    chk("rst_async_mclk", 32'(mclk16), 32'd0);
    chk("rst_async_dac", 32'(dac16), 32'd0);
    chk("rst_async_level", 32'(lvl16), 32'd0);
    chk("rst_async_ready", 32'(rdy16), 32'd1);
    chk("rst_async_sticky", 32'(ufs16), 32'd0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      step();
      if (m_rise) cnt++;
      if (lr_s) ok = 1'b1;
    end
    chk("rst_first_lrck_rises", cnt, 32'd128);
    // 24-bit slot pattern
    use24 = 1'b1;
    step();
    rst24_n = 1'b1;
    step();
    push(24'hABCDEF, 24'h123456);
    cap(1'b0, "d24_left", 32'h55E6_F780);
    cap(1'b1, "d24_right", 32'h091A_2B00);
  endtask

  initial begin
    rst_n = 1'b0; rst24_n = 1'b0; rst_r_n = 1'b0;
    v16 = 1'b0; l16 = '0; r16 = '0;
    v24 = 1'b0; l24 = '0; r24 = '0;
    zero16 = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(rdy16), 32'd1);
    chk("reset_level", 32'(lvl16), 32'd0);
    chk("reset_outs", {28'd0, uf16, ufs16, mclk16, lrck16}, 32'd0);
    chk("reset_dac", 32'(dac16), 32'd0);
    chk("reset24_ready", 32'(rdy24), 32'd1);
    fork
      rate_test();
      main_tests();
    join
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
